// File: rtl/sextium_mem_arbiter.sv
// Two-master round-robin arbiter for the Sextium RAM controller CPU-side port.
// Registered downstream strobes, per-master read-data holding and an ack-timeout watchdog.
module sextium_mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m0_read,
    input  logic          m1_read,
    input  logic          m0_write,
    input  logic          m1_write,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m0_ack,
    output logic          m1_ack,
    output logic          m0_err,
    output logic          m1_err,
    output logic [AW-1:0] addr_bus,
    output logic [DW-1:0] mem_bus_out,
    input  logic [DW-1:0] mem_bus_in,
    output logic          mem_read,
    output logic          mem_write,
    input  logic          mem_ack,
    output logic          grant,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_e;

    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          rr_q, rr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic req0, req1, timeout_hit, sel;

    assign req0        = m0_read | m0_write;
    assign req1        = m1_read | m1_write;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req0 || req1) state_d = REQ;
            REQ:     if (mem_ack || timeout_hit) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m0_ack = (state_q == ACK) && !grant_q;
        m1_ack = (state_q == ACK) &&  grant_q;
        m0_err = m0_ack && err_q;
        m1_err = m1_ack && err_q;
        busy   = (state_q != IDLE);
    end

    // Tie goes to the master the rr pointer does not name; read+write is a write.
    always_comb begin
        grant_d  = grant_q;
        rr_d     = rr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        sel      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req0 || req1) begin
                    sel     = (req0 && req1) ? ~rr_q : req1;
                    grant_d = sel;
                    rr_d    = sel;
                    err_d   = 1'b0;
                    if (sel) begin
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                        wr_d    = m1_write;
                        rd_d    = m1_read & ~m1_write;
                    end else begin
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                        wr_d    = m0_write;
                        rd_d    = m0_read & ~m0_write;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (rd_q) begin
                        if (grant_q) rdata1_d = mem_bus_in;
                        else         rdata0_d = mem_bus_in;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (timeout_hit) begin
                        rd_d  = 1'b0;
                        wr_d  = 1'b0;
                        err_d = 1'b1;
                    end
                end
            end
            ACK:     cnt_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q  <= 1'b0;
            rr_q     <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign addr_bus    = addr_q;
    assign mem_bus_out = wdata_q;
    assign mem_read    = rd_q;
    assign mem_write   = wr_q;
    assign grant       = grant_q;
    assign m0_rdata    = rdata0_q;
    assign m1_rdata    = rdata1_q;

endmodule

// File: tb/tb_sextium_mem_arbiter.sv
// Directed bench for sextium_mem_arbiter with a small RAM-controller model
// whose ack follows req & ~ack and which can be forced to never ack.
module tb_sextium_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_read, m1_read, m0_write, m1_write;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [15:0] addr_bus, mem_bus_out, mem_bus_in;
    logic        mem_read, mem_write, mem_ack;
    logic        grant, busy;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    sextium_mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_read(m0_read), .m1_read(m1_read),
        .m0_write(m0_write), .m1_write(m1_write),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_err(m0_err), .m1_err(m1_err),
        .addr_bus(addr_bus), .mem_bus_out(mem_bus_out), .mem_bus_in(mem_bus_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack),
        .grant(grant), .busy(busy)
    );

    // RAM controller model
    logic [15:0] ram [0:255];
    logic        ack_q = 1'b0;
    logic [15:0] rdq = '0;
    logic        stuck = 1'b0;
    logic        loaded = 1'b0;
    int          n_ack0 = 0, n_ack1 = 0, n_err = 0;

    always @(posedge clock) begin
        if (reset) begin
            ack_q <= 1'b0;
            if (!loaded) begin
                ram[8'h10] <= 16'hBEEF;
                loaded     <= 1'b1;
            end
        end else begin
            ack_q <= (mem_read | mem_write) & ~ack_q & ~stuck;
            if ((mem_read | mem_write) && !ack_q && !stuck) begin
                if (mem_write) ram[addr_bus[7:0]] <= mem_bus_out;
                else           rdq <= ram[addr_bus[7:0]];
            end
        end
        if (m0_ack) n_ack0 <= n_ack0 + 1;
        if (m1_ack) n_ack1 <= n_ack1 + 1;
        if (m0_err || m1_err) n_err <= n_err + 1;
    end
    assign mem_ack    = ack_q;
    assign mem_bus_in = rdq;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_reqs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    // Issues a request in the current (IDLE) cycle and returns the cycle of its ack, or -1.
    task automatic access(input bit m, input bit rd, input bit wr,
                          input logic [15:0] a, input logic [15:0] d, output int lat);
        if (m) begin m1_read = rd; m1_write = wr; m1_addr = a; m1_wdata = d; end
        else   begin m0_read = rd; m0_write = wr; m0_addr = a; m0_wdata = d; end
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (m ? m1_ack : m0_ack) begin
                lat = c;
                break;
            end
        end
        clear_reqs();
        tick();
    endtask

    task automatic test_reset();
        reset = 1; clear_reqs();
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        tick(); tick();
        reset = 0;
        checks++;
        if ({mem_read, mem_write, busy, grant} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_read, mem_write, busy, grant});
        end
        checks++;
        if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_ack: got %b expected 0000", {m0_ack, m1_ack, m0_err, m1_err});
        end
        checks++;
        if ({addr_bus, mem_bus_out, m0_rdata, m1_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {addr_bus, mem_bus_out, m0_rdata, m1_rdata});
        end
    endtask

    task automatic test_cpu_read();
        m0_read = 1; m0_addr = 16'h0010;
        tick();
        checks++;
        if ({mem_read, mem_write, busy} !== 3'b101 || addr_bus !== 16'h0010) begin
            errors++; $display("FAIL read_c1: got rd/wr/busy=%b addr=%h expected 101 0010", {mem_read, mem_write, busy}, addr_bus);
        end
        tick();
        checks++;
        if ({mem_read, mem_ack, m0_ack} !== 3'b110) begin
            errors++; $display("FAIL read_c2: got rd/mack/ack=%b expected 110", {mem_read, mem_ack, m0_ack});
        end
        tick();
        checks++;
        if ({m0_ack, m0_err, m1_ack, mem_read} !== 4'b1000 || m0_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL read_c3: got ack/err/ack1/rd=%b rdata=%h expected 1000 beef", {m0_ack, m0_err, m1_ack, mem_read}, m0_rdata);
        end
        m0_read = 0;
        tick();
        checks++;
        if ({m0_ack, busy} !== 2'b00 || m0_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL read_c4: got ack/busy=%b rdata=%h expected 00 beef", {m0_ack, busy}, m0_rdata);
        end
    endtask

    task automatic test_dma_write_read();
        int lat;
        int n0;
        n0 = n_ack0;
        access(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL dma_write_lat: got %0d expected 3", lat); end
        access(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL dma_read_lat: got %0d expected 3", lat); end
        checks++;
        if (m1_rdata !== 16'h1234) begin errors++; $display("FAIL dma_read_data: got %h expected 1234", m1_rdata); end
        checks++;
        if (n_ack0 !== n0) begin errors++; $display("FAIL dma_no_m0_ack: got %0d expected %0d", n_ack0, n0); end
    endtask

    task automatic test_rw_both();
        int lat;
        m0_read = 1; m0_write = 1; m0_addr = 16'h0030; m0_wdata = 16'h5555;
        tick();
        checks++;
        if ({mem_write, mem_read} !== 2'b10 || mem_bus_out !== 16'h5555) begin
            errors++; $display("FAIL rw_strobe: got wr/rd=%b data=%h expected 10 5555", {mem_write, mem_read}, mem_bus_out);
        end
        tick(); tick();
        checks++;
        if (m0_ack !== 1'b1 || m0_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL rw_ack: got ack=%b rdata=%h expected 1 beef", m0_ack, m0_rdata);
        end
        clear_reqs();
        tick();
        access(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, lat);
        checks++;
        if (lat !== 3 || m0_rdata !== 16'h5555) begin
            errors++; $display("FAIL rw_readback: got lat=%0d rdata=%h expected 3 5555", lat, m0_rdata);
        end
    endtask

    task automatic test_back_to_back();
        reset = 1;
        m0_read = 1; m0_addr = 16'h0010;
        m1_read = 1; m1_addr = 16'h0020;
        tick();
        reset = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            checks++;
            if (m0_ack !== (c == 3 || c == 11) || m1_ack !== (c == 7 || c == 15)) begin
                errors++; $display("FAIL b2b_ack_c%0d: got m0/m1=%b%b expected %b%b", c, m0_ack, m1_ack,
                                   (c == 3 || c == 11), (c == 7 || c == 15));
            end
            if (c == 3 || c == 7) begin
                checks++;
                if (grant !== (c == 7)) begin
                    errors++; $display("FAIL b2b_grant_c%0d: got %b expected %b", c, grant, (c == 7));
                end
            end
        end
        checks++;
        if (m0_rdata !== 16'hBEEF || m1_rdata !== 16'h1234) begin
            errors++; $display("FAIL b2b_data: got %h %h expected beef 1234", m0_rdata, m1_rdata);
        end
        clear_reqs();
        tick();
    endtask

    task automatic test_timeout();
        int cnt;
        int e0;
        int lat;
        e0 = n_err;
        stuck = 1;
        m1_read = 1; m1_addr = 16'h0044;
        tick();
        cnt = 0;
        while (mem_read && cnt < 40) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== 15) begin errors++; $display("FAIL to_strobe_len: got %0d expected 15", cnt); end
        checks++;
        if ({m1_ack, m1_err, m0_ack, m0_err} !== 4'b1100 || m1_rdata !== 16'h1234) begin
            errors++; $display("FAIL to_abort: got ack/err/ack0/err0=%b rdata=%h expected 1100 1234",
                               {m1_ack, m1_err, m0_ack, m0_err}, m1_rdata);
        end
        clear_reqs();
        stuck = 0;
        tick();
        access(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, lat);
        checks++;
        if (lat !== 3 || m1_rdata !== 16'hBEEF || n_err !== e0 + 1) begin
            errors++; $display("FAIL to_recover: got lat=%0d rdata=%h errs=%0d expected 3 beef %0d", lat, m1_rdata, n_err - e0, 1);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int a0;
        m0_read = 1; m0_addr = 16'h0010;
        tick();
        checks++;
        if (mem_read !== 1'b1) begin errors++; $display("FAIL mid_req: got %b expected 1", mem_read); end
        a0 = n_ack0;
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if ({mem_read, mem_write, busy, m0_ack, mem_ack} !== 5'b00000 || m0_rdata !== 16'h0000) begin
            errors++; $display("FAIL mid_reset: got rd/wr/busy/ack/mack=%b rdata=%h expected 00000 0000",
                               {mem_read, mem_write, busy, m0_ack, mem_ack}, m0_rdata);
        end
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (m0_ack) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== 3 || m0_rdata !== 16'hBEEF || n_ack0 !== a0) begin
            errors++; $display("FAIL mid_reissue: got lat=%0d rdata=%h prior_acks=%0d expected 3 beef 0", lat, m0_rdata, n_ack0 - a0);
        end
        clear_reqs();
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write_read();
        test_rw_both();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/sextium_mem_arbiter.md
Name: sextium_mem_arbiter

Overview:
Two-master arbiter sharing the single CPU-side port (port A) of the Sextium RAM controller. Master 0 is the CPU core and master 1 is the DMA/debug engine; both use the same read/write/ack handshake that the RAM controller exposes. The arbiter has round-robin fairness, registered downstream strobes and an optional ack-timeout watchdog. It sits between the masters and the controller's addr_bus/mem_bus_out/mem_bus_in/mem_read/mem_write/mem_ack.

Parameters:
AW, 16, address width
DW, 16, data width
TIMEOUT, 15, cycles in REQ without mem_ack before abort; 0 disables watchdog (width: 8-bit counter, TIMEOUT <= 255)

Ports:
clock  in  1  single system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
m0_addr / m1_addr  in  AW  master address
m0_wdata / m1_wdata  in  DW  master write data
m0_read / m1_read  in  1  read request level, held until ack
m0_write / m1_write  in  1  write request level, held until ack
m0_rdata / m1_rdata  out  DW  read data, valid during ack cycle and held after it
m0_ack / m1_ack  out  1  one-cycle completion pulse
m0_err / m1_err  out  1  asserted with ack when the watchdog aborted the access
addr_bus  out  AW  to controller, registered
mem_bus_out  out  DW  write data to controller, registered
mem_bus_in  in  DW  read data from controller
mem_read / mem_write  out  1  controller strobes, registered
mem_ack  in  1  controller completion
grant  out  1  owner of the current/last transaction (0 = m0, 1 = m1)
busy  out  1  high when state != IDLE

Behaviour:
- States: IDLE, REQ, ACK. Reset forces IDLE. All outputs are 0 after reset, rr pointer = 1 so m0 wins the first tie, and the watchdog counter = 0.
- IDLE: the request for master i is (mi_read|mi_write). If neither requests, stay in IDLE. If one requests, grant it. If both request, grant the master that is not the rr pointer. On a grant, register addr, wdata and op into the downstream regs, update rr pointer and grant, then go to REQ. If read and write are both high, it is a write.
- REQ: mem_read/mem_write stay asserted for the whole state.
  - When mem_ack = 1, capture mem_bus_in into the granted mi_rdata (reads only; writes leave rdata unchanged), drop the strobes and go to ACK.
  - Otherwise, the counter increments. When counter == TIMEOUT-1 and TIMEOUT != 0, drop the strobes, set the err flag and go to ACK.
- ACK: mi_ack (and mi_err if aborted) is high for exactly this cycle for the granted master only. Requests are ignored in this cycle. Next state is IDLE and the counter clears.
- Latency: request high in cycle 0 (IDLE) -> strobe high in cycles 1-2 -> mem_ack high in cycle 2 -> mi_ack in cycle 3. The next grant decision is made in cycle 4, so throughput is 1 access per 4 cycles.
- The strobe is never high in a cycle following mem_ack. This matches the controller's ack = req & ~ack toggling, so no double ack is possible.
- A request dropped by a master while in REQ is not cancelled; the transaction completes.
- mem_ack seen in IDLE or ACK is ignored.
- Reset mid-transaction: the next cycle is IDLE, strobes are 0 and no ack is issued. Masters must re-issue the request.

Test Plan:
- Reset then m0_read addr 0x0010 (RAM holds 0xBEEF) -> mem_read high in cycles 1-2, mem_ack in cycle 2, m0_ack + m0_rdata = 0xBEEF in cycle 3, m0_err = 0.
- m1_write addr 0x0020 data 0x1234, then m1_read 0x0020 -> second ack returns 0x1234; m0 sees no ack.
- m0 and m1 both request continuously from reset -> grants alternate 0,1,0,1; each ack is 4 cycles apart and the first goes to m0.
- m0 has read and write both high, addr 0x0030, wdata 0x5555 -> mem_write is issued (not mem_read); a later read of 0x0030 returns 0x5555.
- With mem_ack stuck at 0 and TIMEOUT = 15 -> strobe high for 15 cycles, then mi_ack + mi_err pulse; next request proceeds normally.
- Reset asserted during REQ -> strobes 0 and busy 0 next cycle, no ack; re-issued request completes with the normal cycle-3 ack.
